// File: rtl/uart_frame_arbiter.sv
// rtl/uart_frame_arbiter.sv - round-robin arbiter framing 16-bit results onto one UART_TX byte transmitter.
// Define UART_ARB_CHECKSUM_EN to append an XOR checksum byte (4-byte frames instead of 3).
module uart_frame_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 uart_start,
  output logic [7:0]           uart_data,
  input  logic                 uart_busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
);

`ifdef UART_ARB_CHECKSUM_EN
  localparam logic [1:0] LAST = 2'd3;
`else
  localparam logic [1:0] LAST = 2'd2;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GUARD,
    S_WAIT
  } state_t;

  state_t            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [IDW-1:0]    grant_id_q;
  logic [1:0]        idx_q;
  logic [15:0]       word_q;
  logic [NREQ-1:0]   req_ready_q;
  logic              uart_start_q;
  logic [7:0]        uart_data_q;
  logic              busy_q;

  logic              win_found;
  logic [IDW-1:0]    win_id;
  logic [15:0]       win_data;
  logic [IDW-1:0]    ptr_d;
  logic [1:0]        idx_d;
  logic [7:0]        byte_d;

  function automatic logic [7:0] header_byte(input logic [IDW-1:0] id);
    return {4'hA, 4'(id)};
  endfunction

  // First pending requester at or after ptr_q, wrapping modulo NREQ.
  always_comb begin : rr_select
    int c;
    c         = 0;
    win_found = 1'b0;
    win_id    = '0;
    win_data  = '0;
    for (int k = 0; k < NREQ; k++) begin
      c = int'(ptr_q) + k;
      if (c >= NREQ) c = c - NREQ;
      if (!win_found && req_valid[c]) begin
        win_found = 1'b1;
        win_id    = IDW'(c);
        win_data  = req_data[16*c +: 16];
      end
    end
  end

  always_comb begin
    ptr_d = '0;
    if (int'(win_id) != NREQ - 1) ptr_d = win_id + IDW'(1);
  end

  assign idx_d = idx_q + 2'd1;

  always_comb begin
    byte_d = 8'h00;
    case (idx_d)
      2'd1: byte_d = word_q[15:8];
      2'd2: byte_d = word_q[7:0];
`ifdef UART_ARB_CHECKSUM_EN
      2'd3: byte_d = header_byte(grant_id_q) ^ word_q[15:8] ^ word_q[7:0];
`endif
      default: byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      grant_id_q   <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      req_ready_q  <= '0;
      uart_start_q <= 1'b0;
      uart_data_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      uart_start_q <= 1'b0;
      req_ready_q  <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found) begin
            word_q       <= win_data;
            grant_id_q   <= win_id;
            ptr_q        <= ptr_d;
            idx_q        <= '0;
            req_ready_q  <= NREQ'(1) << win_id;
            uart_start_q <= 1'b1;
            uart_data_q  <= header_byte(win_id);
            busy_q       <= 1'b1;
            state_q      <= S_SEND;
          end
        end
        S_SEND:  state_q <= S_GUARD;
        // UART_TX raises busy one cycle after start, so it is not trusted here.
        S_GUARD: state_q <= S_WAIT;
        S_WAIT: begin
          if (!uart_busy) begin
            if (idx_q < LAST) begin
              idx_q        <= idx_d;
              uart_data_q  <= byte_d;
              uart_start_q <= 1'b1;
              state_q      <= S_SEND;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign uart_start = uart_start_q;
  assign uart_data  = uart_data_q;
  assign grant_id   = grant_id_q;
  assign busy       = busy_q;

endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Shares the single `UART_TX` byte transmitter between `NREQ` result producers, for example several ALU/FSM lanes. It picks one pending requester by round-robin and captures its 16-bit result. It then sequences the transmitter through a framed multi-byte transfer: header, result high byte, result low byte, and an optional checksum. It replaces the single fixed start/send/wait loop in front of the transmitter and sits between the requesters and `UART_TX`.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, legal range 2..16.
- `IDW`, default 4: width of the requester id field. Must satisfy 2^IDW >= NREQ.

Ports (clock and reset first):
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_data`  in  16*NREQ  result of requester i, in bits [16i+15:16i].
- `req_ready`  out  NREQ  one-cycle grant/capture pulse to the winning requester.
- `uart_start`  out  1  one-cycle start pulse to `UART_TX`.
- `uart_data`  out  8  byte to `UART_TX`; stable from the start pulse until the next start pulse.
- `uart_busy`  in  1  busy signal from `UART_TX`.
- `grant_id`  out  IDW  id of the requester whose frame is in progress.
- `busy`  out  1  high from capture until the frame's last byte completes.

## Operation
- States:
  - IDLE: waits for a request.
  - SEND: `uart_start`=1 for one cycle.
  - GUARD: one cycle in which `uart_busy` is ignored.
  - WAIT: waits for `uart_busy`=0.
- Byte counter `idx` runs 0..LAST, where LAST=2 without checksum and 3 with it.
- IDLE, when any `req_valid` bit is set:
  - Selects the first set bit searching upward from `ptr`, wrapping modulo NREQ.
  - Captures that requester's `req_data` into `word` and its id into `grant_id`.
  - Sets `ptr` = winner+1, wrapping to 0 after NREQ-1.
  - Sets `idx`=0 and moves to SEND.
- SEND:
  - Drives `uart_start`=1 and `uart_data`=byte[idx]; drives `req_ready[grant_id]`=1 only when idx=0.
  - Moves to GUARD.
- GUARD: moves to WAIT unconditionally. This covers the one-cycle latency of `UART_TX` raising busy.
- WAIT, when `uart_busy`=0:
  - If idx<LAST: idx++ and move to SEND.
  - Otherwise move to IDLE.
- Byte values:
  - byte0 = {4'hA, grant_id zero-extended/truncated to 4 bits}.
  - byte1 = word[15:8].
  - byte2 = word[7:0].
  - byte3 = byte0 ^ byte1 ^ byte2.
- Requester rules:
  - A requester holds `req_valid` and `req_data` stable until it sees `req_ready`.
  - It deasserts or updates them in the cycle after `req_ready`.
  - Data is captured at grant, so later changes to `req_data` do not affect the frame in progress.
- `req_valid` bits that drop before being granted are simply skipped; no error is raised.
- Simultaneous requests: round-robin order guarantees every requester is served within NREQ frames.
- If `uart_busy` never falls, the block waits in WAIT indefinitely. There is no timeout.
- Reset, including mid-frame:
  - State=IDLE, `ptr`=0, `idx`=0, `word`=0.
  - All outputs go to 0 immediately (asynchronous), including `uart_start`, `uart_data`, `req_ready`, `grant_id` and `busy`.
  - A partially sent frame is abandoned, not resumed.

## Timing
- Edge E0 in IDLE with a request: the grant is taken.
- Cycle after E0: SEND, with `uart_start`=1, `req_ready` pulsed, `busy`=1 and byte0 on `uart_data`.
- Minimum spacing between start pulses: 3 cycles (SEND, GUARD, WAIT with busy already low).
- `busy` falls on the edge leaving WAIT after the last byte.
- Earliest next grant: the first IDLE cycle after `busy` falls. There is one IDLE cycle minimum between frames.
- All outputs are registered or decoded directly from the registered state; there are no combinational paths from inputs to outputs.

## Configuration
- `UART_ARB_CHECKSUM_EN`:
  - Defined: LAST=3 and byte3 (XOR checksum) is appended, giving 4-byte frames.
  - Undefined: LAST=2, 3-byte frames, and the checksum logic is absent.

## Test plan
- Single request: NREQ=4, checksum on, `req_valid`=4'b0100, data 16'h1234, `UART_TX` model with 10-cycle busy.
  - One `req_ready[2]` pulse.
  - Bytes sent: A2, 12, 34, 84.
  - `busy` returns to 0 after the last byte.
- Round-robin: all four requesters valid continuously, each dropping valid after its `req_ready`.
  - Grant order 0,1,2,3.
  - A repeat request from 0 is then served only after 1..3 have been served.
- Pointer wrap: `ptr`=3 after serving requester 2, with requests pending on 0 and 1.
  - Requester 0 wins; `ptr` becomes 1.
- Checksum off: `UART_ARB_CHECKSUM_EN` undefined, requester 1, data 16'hBEEF.
  - Exactly 3 start pulses, bytes A1, BE, EF.
- Data change after grant: `req_data` changes to 16'h0000 the cycle after `req_ready`, original value 16'hCAFE.
  - Bytes CA, FE are still sent.
- Reset during the byte1 WAIT.
  - All outputs 0 at once.
  - After release with requester 0 valid, a fresh frame starts at byte0 = A0.
